// File: rtl/cpu_dec_uart.sv
// Memory-mapped 8N1 UART responder on the cpu_dec bus.
// TX and RX bytes are buffered in FIFOs. Read responses return one cycle after the request.
module cpu_dec_uart #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_request,
    input  logic        dec_write,
    input  logic [7:0]  dec_address,
    input  logic [3:0]  dec_wstrb,
    input  logic [31:0] dec_wdata,
    output logic        dec_rvalid,
    output logic [31:0] dec_rdata,
    output logic [8:0]  dec_rtag,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic        w_wr, w_rd, w_st_clr;
    logic [1:0]  w_sel;
    logic [31:0] w_rd_data;
    logic        w_unused;

    logic [7:0]  r_tx_mem [FIFO_DEPTH];
    logic [AW:0] r_tx_wp, r_tx_rp, w_tx_used;
    logic [PW-1:0] w_tx_free;
    logic        w_tx_empty, w_tx_full, w_tx_wr, w_tx_push, w_tx_ovf, w_tx_pop, w_tx_busy, w_tx_tick;
    uart_state_t r_tx_state, w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;

    logic [7:0]  r_rx_mem [FIFO_DEPTH];
    logic [AW:0] r_rx_wp, r_rx_rp;
    logic        w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_ferr, w_rx_tick, w_rx_fall;
    uart_state_t r_rx_state, w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;

    logic        r_txovf, r_rxovf, r_ferr;

    assign w_wr     = dec_request & dec_write;
    assign w_rd     = dec_request & ~dec_write;
    assign w_sel    = dec_address[3:2];
    assign w_st_clr = w_wr && (w_sel == 2'd2) && dec_wstrb[0];
    assign w_unused = ^{dec_address[7:4], dec_address[1:0], dec_wstrb[3:1], dec_wdata[31:9]};

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
    assign w_tx_used  = r_tx_wp - r_tx_rp;
    assign w_tx_free  = PW'(FIFO_DEPTH) - w_tx_used;
    assign w_tx_wr    = w_wr && (w_sel == 2'd0) && dec_wstrb[0];
    assign w_tx_push  = w_tx_wr && !w_tx_full;
    assign w_tx_ovf   = w_tx_wr && w_tx_full;
    assign w_tx_busy  = (r_tx_state != ST_IDLE);
    assign w_tx_tick  = (r_tx_cnt == BIT_END);

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
    assign w_rx_pop   = w_rd && (w_sel == 2'd1) && !w_rx_empty;
    assign w_rx_fall  = r_rx_prev & ~r_rx_s2;
    assign w_rx_tick  = (r_rx_state == ST_START) ? (r_rx_cnt == HALF_END) : (r_rx_cnt == BIT_END);

    always_ff @(posedge clock) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= dec_wdata[7:0];
        if (w_rx_push && !w_rx_full) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
            if (w_rx_push && !w_rx_full) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as a software clear takes priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_txovf <= 1'b0;
            r_rxovf <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_txovf <= w_tx_ovf ? 1'b1 : (w_st_clr && dec_wdata[3]) ? 1'b0 : r_txovf;
            r_rxovf <= (w_rx_push && w_rx_full) ? 1'b1 : (w_st_clr && dec_wdata[4]) ? 1'b0 : r_rxovf;
            r_ferr  <= w_rx_ferr ? 1'b1 : (w_st_clr && dec_wdata[5]) ? 1'b0 : r_ferr;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            2'd0:    w_rd_data = 32'(w_tx_free);
            2'd1:    w_rd_data = w_rx_empty ? '1 : {24'h0, r_rx_mem[r_rx_rp[AW-1:0]]};
            2'd2:    w_rd_data = {26'h0, r_ferr, r_rxovf, r_txovf, ~w_rx_empty, w_tx_busy, w_tx_empty};
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_rvalid <= 1'b0;
            dec_rdata  <= '0;
            dec_rtag   <= '0;
        end else begin
            dec_rvalid <= w_rd;
            if (w_rd) begin
                dec_rdata <= w_rd_data;
                dec_rtag  <= dec_wdata[8:0];
            end
        end
    end

    // TX FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '1;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= (r_tx_state == ST_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
            if (w_tx_pop) begin
                r_tx_shift <= r_tx_mem[r_tx_rp[AW-1:0]];
                r_tx_bit   <= '0;
            end else if (r_tx_state == ST_DATA && w_tx_tick) begin
                r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 1'b1;
            end
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            ST_IDLE:  if (!w_tx_empty) w_tx_next = ST_START;
            ST_START: if (w_tx_tick) w_tx_next = ST_DATA;
            ST_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = ST_STOP;
            ST_STOP:  if (w_tx_tick) w_tx_next = w_tx_empty ? ST_IDLE : ST_START;
            default:  w_tx_next = ST_IDLE;
        endcase
    end

    // A queued byte is popped on the last STOP cycle so the next frame follows immediately.
    always_comb begin
        uart_tx  = 1'b1;
        w_tx_pop = 1'b0;
        case (r_tx_state)
            ST_IDLE:  w_tx_pop = !w_tx_empty;
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = r_tx_shift[0];
            ST_STOP:  w_tx_pop = w_tx_tick && !w_tx_empty;
            default:  uart_tx = 1'b1;
        endcase
    end

    // RX FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= (r_rx_state == ST_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
            if (r_rx_state == ST_IDLE) begin
                r_rx_bit <= '0;
            end else if (r_rx_state == ST_DATA && w_rx_tick) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
            end
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            ST_IDLE:  if (w_rx_fall) w_rx_next = ST_START;
            ST_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = ST_STOP;
            ST_STOP:  if (w_rx_tick) w_rx_next = ST_IDLE;
            default:  w_rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rx_push = 1'b0;
        w_rx_ferr = 1'b0;
        if (r_rx_state == ST_STOP && w_rx_tick) begin
            w_rx_push = r_rx_s2;
            w_rx_ferr = ~r_rx_s2;
        end
    end
endmodule
